lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store initiator that sits between the CPU datapath and the word-wide data memory. The memory has no byte enables and has registered (synchronous) read data. This block therefore turns each lw/lh/lhu/lb/lbu/sw/sh/sb request into a sequence of whole-word memory reads and writes, using read-modify-write for sub-word stores. It sign- or zero-extends load data and returns one response per request over a valid/ready handshake.

## Interface
- `MEM_AW`, default 10, word-address width of the data memory (1024 words).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_op`  in  3  operation code (see Structure).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; sub-word stores use the low bits.
- `rsp_valid`  out  1  response available; held until accepted.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned access; no memory access was made.
- `mem_addr`  out  MEM_AW  word address, equal to `req_addr[MEM_AW+1:2]` latched at accept.
- `mem_re`  out  1  read strobe; data is returned on `mem_rdata` in the next cycle.
- `mem_we`  out  1  write strobe; the memory writes `mem_wdata` at this edge.
- `mem_wdata`  out  32  write word.
- `mem_rdata`  in  32  read word, valid in the cycle after `mem_re`.

## Operation
- **FSM states:** IDLE, RD, CAP, WR, RSP.
- **Accept:** a request is accepted on an edge where `req_valid && req_ready` is true. At that edge the block latches op, address and wdata.
  - If the access is misaligned, the FSM goes to RSP with `rsp_err=1`.
  - Otherwise sw goes to WR, and every other op goes to RD.
- **Misaligned:**
  - lw/sw with `addr[1:0]!=0`.
  - lh/lhu/sh with `addr[0]=1`.
  - Byte ops are never misaligned.
- **RD:** `mem_re=1`. Next state is CAP.
- **CAP:** `mem_rdata` is valid in this cycle.
  - Loads: select the lane by `addr[1:0]`, then extend. lh/lb sign-extend; lhu/lbu zero-extend; lw passes the word through. Latch the result into `rsp_rdata`. Next state is RSP.
  - sh/sb: replace only the addressed lane of `mem_rdata` with `req_wdata[15:0]` or `req_wdata[7:0]`, and latch the merged word. Next state is WR.
- **WR:** `mem_we=1`. `mem_wdata` is the merged word for sh/sb, or `req_wdata` for sw. Next state is RSP.
- **RSP:** `rsp_valid=1`. On `rsp_ready`, go to IDLE. A new request can be accepted no earlier than the cycle after the response is accepted.
- **Lane mapping:** little-endian. Byte k occupies bits [8k+7:8k]. The halfword at `addr[1]=1` is bits [31:16].
- **Address aliasing:** address bits above `MEM_AW+1` are ignored and alias, matching the memory.
- **Strobes:** at most one of `mem_re`/`mem_we` is high in any cycle. Neither is high outside RD/WR.

## Timing
- **Reset values:** state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `mem_re=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- **Latency** (accept edge to the first cycle with `rsp_valid` high):
  - loads: 3 cycles.
  - sw: 2 cycles.
  - sh/sb: 4 cycles.
  - misaligned: 1 cycle.
- **Response hold:** `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable while `rsp_ready` is low.
- **Back-pressure:** `req_ready` is 0 in every state except IDLE. `req_*` inputs are ignored outside IDLE.
- **Reset mid-operation:** the FSM returns to IDLE asynchronously and `mem_we` drops immediately.
  - A pending RMW write is discarded, so no partial word is written.
  - Any in-flight response is lost.
- **Outputs:** all outputs are registered or decoded from the state register only, with no combinational path from `req_*` to `mem_*`.

## Structure
- **Shared package `lsu_pkg`:**
  - op codes: LW=3'b000, LH=001, LHU=010, LB=011, LBU=100, SW=101, SH=110, SB=111.
  - the FSM state enum.
  - an `is_store` helper.
- **Sub-module `lsu_lane_unit`:** combinational. It holds the lane-extract/extend logic and the lane-merge logic, shared by CAP for both loads and stores.

## Test plan
- **lw:** preload word 5 = 0x8899AABB; lw addr 0x14 -> `mem_re` pulse with `mem_addr=5`, then `rsp_rdata=0x8899AABB` three cycles after accept.
- **Sub-word loads:** same word; lb 0x17 -> 0xFFFFFF88; lbu 0x17 -> 0x00000088; lh 0x14 -> 0xFFFFAABB; lhu 0x16 -> 0x00008899.
- **sb:** word 5 = 0x8899AABB; sb 0x15 with wdata 0x123456CC -> one read, then `mem_we` with `mem_wdata=0x8899CCBB`; a follow-up lw returns the same value.
- **Misaligned:** lw 0x16 and sh 0x15 -> `rsp_err=1` after 1 cycle, `rsp_rdata=0`, no `mem_re` and no `mem_we` seen.
- **Back-pressure:** hold `rsp_ready=0` for 5 cycles during a lw -> response held stable, `req_ready=0` throughout; accept, then next request taken the following cycle.
- **Reset mid-RMW:** assert `reset` in CAP of an sh -> `mem_we` never asserts, memory is unchanged, and outputs match reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op codes, FSM states and decode helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        OpLw  = 3'b000,
        OpLh  = 3'b001,
        OpLhu = 3'b010,
        OpLb  = 3'b011,
        OpLbu = 3'b100,
        OpSw  = 3'b101,
        OpSh  = 3'b110,
        OpSb  = 3'b111
    } lsu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StRsp
    } lsu_state_e;

    function automatic logic is_store(lsu_op_e op);
        return (op == OpSw) || (op == OpSh) || (op == OpSb);
    endfunction

    function automatic logic is_misaligned(lsu_op_e op, logic [1:0] off);
        unique case (op)
            OpLw, OpSw:       return off != 2'b00;
            OpLh, OpLhu, OpSh: return off[0];
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// CPU-side request/response and word-memory bus of the load/store unit.
interface lsu_mem_ctrl_if #(
    parameter int unsigned MEM_AW = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // master is the environment (datapath + memory), slave is the controller
    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: extract/extend for loads, lane merge for sub-word stores.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [4:0]  bit_off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign bit_off  = {offset, 3'b000};
    assign byte_sel = rdata[bit_off +: 8];
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (op)
            OpLh:    load_data = {{16{half_sel[15]}}, half_sel};
            OpLhu:   load_data = {16'h0000, half_sel};
            OpLb:    load_data = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   load_data = {24'h000000, byte_sel};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        case (op)
            OpSh: begin
                if (offset[1]) merge_data[31:16] = wdata;
                else           merge_data[15:0]  = wdata;
            end
            OpSb:    merge_data[bit_off +: 8] = wdata[7:0];
            default: merge_data = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: maps byte/half/word accesses onto a word-only synchronous memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input logic           clk,
    input logic           reset,
    lsu_mem_ctrl_if.slave bus
);
    lsu_state_e        state_q;
    lsu_op_e           op_q;
    lsu_op_e           req_op;
    logic [1:0]        off_q;
    logic [15:0]       wdata_q;
    logic [MEM_AW-1:0] addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              req_misaligned;

    assign req_op         = lsu_op_e'(bus.req_op);
    assign req_misaligned = is_misaligned(req_op, bus.req_addr[1:0]);

    lsu_lane_unit u_lane (
        .op         (op_q),
        .offset     (off_q),
        .rdata      (bus.mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= OpLw;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        op_q        <= req_op;
                        off_q       <= bus.req_addr[1:0];
                        addr_q      <= bus.req_addr[MEM_AW+1:2];
                        wdata_q     <= bus.req_wdata[15:0];
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= req_misaligned;
                        if (req_misaligned) begin
                            state_q <= StRsp;
                        end else if (req_op == OpSw) begin
                            mem_wdata_q <= bus.req_wdata;
                            state_q     <= StWr;
                        end else begin
                            state_q <= StRd;
                        end
                    end
                end
                StRd: state_q <= StCap;
                StCap: begin
                    // only loads and sub-word stores pass through CAP
                    if (is_store(op_q)) begin
                        mem_wdata_q <= merge_data;
                        state_q     <= StWr;
                    end else begin
                        rsp_rdata_q <= load_data;
                        state_q     <= StRsp;
                    end
                end
                StWr: state_q <= StRsp;
                StRsp: begin
                    if (bus.rsp_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes and handshakes decode the state register so reset drops them at once
    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StRsp);
    assign bus.mem_re    = (state_q == StRd);
    assign bus.mem_we    = (state_q == StWr);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a behavioural memory and reference model.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          re_n;
        int          we_n;
        logic [31:0] we_data;
        logic [9:0]  addr;
    } exp_t;

    logic clk;
    logic reset;
    logic mem_init;

    lsu_mem_ctrl_if #(.MEM_AW(10)) bus ();

    lsu_mem_ctrl #(.MEM_AW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    exp_t        exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int we_total = 0;
    int hold     = 0;

    function automatic logic [31:0] init_word(int i);
        if (i == 5) return 32'h8899AABB;
        return (i * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else begin
            if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic timeout(string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Reference model: whole-request semantics from byte address, op and memory image.
    function automatic exp_t model(lsu_op_e op, logic [31:0] addr, logic [31:0] wd);
        exp_t        e;
        int          idx;
        int          off;
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] mask;
        idx = int'(addr[11:2]);
        off = int'(addr[1:0]);
        w   = ref_mem[idx];
        e.rdata = 32'h0; e.err = 1'b0; e.lat = 0; e.re_n = 0; e.we_n = 0;
        e.we_data = 32'h0; e.addr = addr[11:2];
        if (((op == OpLw || op == OpSw) && off != 0) ||
            ((op == OpLh || op == OpLhu || op == OpSh) && (off % 2) == 1)) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (8 * off)) & 32'hFFFF;
        case (op)
            OpLw:  begin e.rdata = w; e.lat = 3; e.re_n = 1; end
            OpLb:  begin e.rdata = (b >= 128) ? b + 32'hFFFFFF00 : b; e.lat = 3; e.re_n = 1; end
            OpLbu: begin e.rdata = b; e.lat = 3; e.re_n = 1; end
            OpLh:  begin e.rdata = (h >= 32768) ? h + 32'hFFFF0000 : h; e.lat = 3; e.re_n = 1; end
            OpLhu: begin e.rdata = h; e.lat = 3; e.re_n = 1; end
            OpSw:  begin e.we_data = wd; e.lat = 2; e.we_n = 1; end
            default: begin
                mask = (op == OpSb) ? 32'hFF : 32'hFFFF;
                e.we_data = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
                e.lat = 4; e.re_n = 1; e.we_n = 1;
            end
        endcase
        if (e.we_n == 1) ref_mem[idx] = e.we_data;
        return e;
    endfunction

    // Monitor: tracks each accepted request and scores the response against the queue.
    int          acc_cyc = 0;
    int          re_n = 0;
    int          we_n = 0;
    logic [31:0] we_data = 0;
    logic [9:0]  we_addr = 0;
    logic [9:0]  re_addr = 0;
    bit          in_rsp = 0;
    bit          rsp_acc_prev = 0;
    logic [31:0] held_rdata = 0;
    logic        held_err = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            in_rsp = 0; re_n = 0; we_n = 0; rsp_acc_prev = 0;
        end else begin
            if (rsp_acc_prev) begin
                chk("req_ready_after_rsp", 32'(bus.req_ready), 32'd1);
                rsp_acc_prev = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc = cyc; re_n = 0; we_n = 0; we_data = 0;
            end
            if (bus.mem_re || bus.mem_we)
                chk("one_strobe", 32'(bus.mem_re && bus.mem_we), 32'd0);
            if (bus.mem_re) begin re_n++; re_addr = bus.mem_addr; end
            if (bus.mem_we) begin
                we_n++; we_total++; we_data = bus.mem_wdata; we_addr = bus.mem_addr;
            end
            if (in_rsp) begin
                chk("rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
                chk("rsp_rdata_held", bus.rsp_rdata, held_rdata);
                chk("rsp_err_held", 32'(bus.rsp_err), 32'(held_err));
            end else if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_rsp");
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("mem_re_count", 32'(re_n), 32'(e.re_n));
                    chk("mem_we_count", 32'(we_n), 32'(e.we_n));
                    if (e.re_n > 0) chk("mem_re_addr", 32'(re_addr), 32'(e.addr));
                    if (e.we_n > 0) begin
                        chk("mem_wdata", we_data, e.we_data);
                        chk("mem_we_addr", 32'(we_addr), 32'(e.addr));
                    end
                end
                in_rsp = 1;
                held_rdata = bus.rsp_rdata;
                held_err = bus.rsp_err;
            end
            if (bus.rsp_valid) chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (in_rsp && bus.rsp_valid && bus.rsp_ready) begin
                in_rsp = 0; done_cnt++; rsp_acc_prev = 1;
            end
        end
    end

    // Response back-pressure: random, or forced low for `hold` response cycles.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                bus.rsp_ready = 1'b0;
                if (bus.rsp_valid) hold--;
            end else begin
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    endtask

    task automatic issue(lsu_op_e op, logic [31:0] addr, logic [31:0] wd, bit rst_mid);
        bit got;
        int start;
        int idx;
        int we_before;
        if (!rst_mid) exp_q.push_back(model(op, addr, wd));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin got = 1; break; end
        end
        if (!got) begin timeout("accept_wait"); bus.req_valid = 1'b0; return; end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        if (rst_mid) begin
            idx = int'(addr[11:2]);
            we_before = we_total;
            @(posedge clk);
            #2;
            reset = 1'b1;
            #1;
            check_reset_values();
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            chk("rmw_mem_unchanged", mem[idx], ref_mem[idx]);
            chk("rmw_no_write", 32'(we_total), 32'(we_before));
            return;
        end
        start = done_cnt;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start) begin got = 1; break; end
        end
        if (!got) timeout("response_wait");
    endtask

    initial begin
        reset = 1'b1;
        mem_init = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op = 3'd0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        mem_init = 1'b0;

        issue(OpLw,  32'h14, 32'h0, 0);
        issue(OpLb,  32'h17, 32'h0, 0);
        issue(OpLbu, 32'h17, 32'h0, 0);
        issue(OpLh,  32'h14, 32'h0, 0);
        issue(OpLhu, 32'h16, 32'h0, 0);
        issue(OpSb,  32'h15, 32'h123456CC, 0);
        issue(OpLw,  32'h14, 32'h0, 0);
        issue(OpLw,  32'h16, 32'h0, 0);
        issue(OpSh,  32'h15, 32'hABCD1234, 0);
        hold = 5;
        issue(OpLw,  32'h14, 32'h0, 0);
        issue(OpSw,  32'hFFFF_F020, 32'hCAFEF00D, 0);
        issue(OpLw,  32'h20, 32'h0, 0);
        issue(OpSh,  32'h14, 32'h0000BEEF, 1);
        issue(OpLw,  32'h14, 32'h0, 0);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
                32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) hold = $urandom_range(1, 6);
            issue(lsu_op_e'($urandom_range(0, 7)), a, $urandom, 0);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end
endmodule
